// File: rtl/multi_mode_range_finder.sv
// multi_mode_range_finder
//   Tracks the running minimum and maximum of a sample stream between a go
//   strobe and a finish strobe, then publishes min, max, range (max-min),
//   sample count and a one-cycle done pulse. Comparison is signed or unsigned,
//   selected at session start. Protocol misuse sets a sticky error flag; a
//   saturated sample counter sets a sticky overflow flag.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   data_in      sample (WIDTH bits)
//   in_valid     data_in carries a sample this cycle (ACTIVE only)
//   signed_mode  1 = two's-complement compare, 0 = unsigned; latched on go
//   go / finish  start / end a session
//   min_out      session minimum (raw bit pattern)
//   max_out      session maximum (raw bit pattern)
//   range        max-min as unsigned WIDTH bits
//   count        samples taken, saturating at 2^CNT_WIDTH-1
//   done         one-cycle pulse when results update
//   busy         high while ACTIVE or FINAL
//   error        sticky protocol error (cleared by an accepted go)
//   overflow     sticky counter saturation (cleared by an accepted go)
module multi_mode_range_finder #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 in_valid,
  input  logic                 signed_mode,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     range,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FINAL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     run_min_q, run_min_d;
  logic [WIDTH-1:0]     run_max_q, run_max_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [WIDTH-1:0]     range_q, range_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 overflow_q, overflow_d;

  // a < b under the latched compare mode
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             sm);
    if (sm) begin
      return ($signed(a) < $signed(b));
    end else begin
      return (a < b);
    end
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    run_min_d  = run_min_q;
    run_max_d  = run_max_q;
    run_cnt_d  = run_cnt_q;
    min_d      = min_q;
    max_d      = max_q;
    range_d    = range_q;
    count_d    = count_q;
    done_d     = 1'b0;
    error_d    = error_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (finish) begin
          // finish alone or with go is a protocol error; session not started
          error_d = 1'b1;
        end else if (go) begin
          // go-cycle sample is taken regardless of in_valid
          mode_d     = signed_mode;
          run_min_d  = data_in;
          run_max_d  = data_in;
          run_cnt_d  = CNT_ONE;
          error_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (go) begin
          // re-go mid-session aborts without publishing results
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (in_valid) begin
            if (less_than(data_in, run_min_q, mode_q)) begin
              run_min_d = data_in;
            end else begin
              run_min_d = run_min_q;
            end
            if (less_than(run_max_q, data_in, mode_q)) begin
              run_max_d = data_in;
            end else begin
              run_max_d = run_max_q;
            end
            if (run_cnt_q == CNT_MAX) begin
              overflow_d = 1'b1;
            end else begin
              run_cnt_d = run_cnt_q + CNT_ONE;
            end
          end else begin
            run_cnt_d = run_cnt_q;
          end
          if (finish) begin
            state_d = ST_FINAL;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_FINAL: begin
        min_d   = run_min_q;
        max_d   = run_max_q;
        // modular subtraction yields the correct unsigned span in both modes
        range_d = run_max_q - run_min_q;
        count_d = run_cnt_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ACTIVE) || (state_d == ST_FINAL);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      run_min_q  <= '0;
      run_max_q  <= '0;
      run_cnt_q  <= '0;
      min_q      <= '0;
      max_q      <= '0;
      range_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      run_min_q  <= run_min_d;
      run_max_q  <= run_max_d;
      run_cnt_q  <= run_cnt_d;
      min_q      <= min_d;
      max_q      <= max_d;
      range_q    <= range_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  assign min_out  = min_q;
  assign max_out  = max_q;
  assign range    = range_q;
  assign count    = count_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multi_mode_range_finder.sv
// Directed self-checking bench for multi_mode_range_finder (WIDTH=8,
// CNT_WIDTH=4). Expected session results are pushed to a scoreboard queue
// when finish is driven and popped when done is observed.
module tb_multi_mode_range_finder;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          in_valid;
  logic          signed_mode;
  logic          go;
  logic          finish;
  logic [W-1:0]  min_out;
  logic [W-1:0]  max_out;
  logic [W-1:0]  range;
  logic [CW-1:0] count;
  logic          done;
  logic          busy;
  logic          error;
  logic          overflow;

  typedef struct {
    logic [W-1:0]  mn;
    logic [W-1:0]  mx;
    logic [W-1:0]  rg;
    logic [CW-1:0] cnt;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  multi_mode_range_finder #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .go          (go),
    .finish      (finish),
    .min_out     (min_out),
    .max_out     (max_out),
    .range       (range),
    .count       (count),
    .done        (done),
    .busy        (busy),
    .error       (error),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic g, input logic f, input logic v, input logic [W-1:0] d);
    go       = g;
    finish   = f;
    in_valid = v;
    data_in  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] mn, input logic [W-1:0] mx,
                          input logic [W-1:0] rg, input logic [CW-1:0] cnt);
    res_t r;
    r.mn = mn; r.mx = mx; r.rg = rg; r.cnt = cnt;
    sb.push_back(r);
  endtask

  // call right after the finish step: FINAL cycle, then results + done
  task automatic expect_result(input string tag);
    res_t r;
    chk({tag, "_busy_final"}, 32'(busy), 32'd1);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "_min"},   32'(min_out), 32'(r.mn));
      chk({tag, "_max"},   32'(max_out), 32'(r.mx));
      chk({tag, "_range"}, 32'(range),   32'(r.rg));
      chk({tag, "_count"}, 32'(count),   32'(r.cnt));
    end else begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; data_in = '0; in_valid = 1'b0; signed_mode = 1'b0;
    go = 1'b0; finish = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_min", 32'(min_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // 1: unsigned basic session
    signed_mode = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h20);
    chk("t1_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h05);
    step(1'b0, 1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    push_exp(8'h05, 8'hF0, 8'hEB, 4'd5);
    step(1'b0, 1'b1, 1'b1, 8'h10);
    expect_result("t1");
    chk("t1_err", 32'(error), 32'd0);

    // 2a: signed mode, toggle mode mid-session
    signed_mode = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h80);
    signed_mode = 1'b0;
    push_exp(8'h80, 8'h7F, 8'hFF, 4'd2);
    step(1'b0, 1'b1, 1'b1, 8'h7F);
    expect_result("t2s");

    // 2b: unsigned mode, toggle mode mid-session
    signed_mode = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h80);
    signed_mode = 1'b1;
    push_exp(8'h7F, 8'h80, 8'h01, 4'd2);
    step(1'b0, 1'b1, 1'b1, 8'h7F);
    expect_result("t2u");
    signed_mode = 1'b0;

    // 3: protocol errors in IDLE
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("t3_gf_err", 32'(error), 32'd1);
    chk("t3_gf_busy", 32'(busy), 32'd0);
    chk("t3_gf_done", 32'(done), 32'd0);
    chk("t3_gf_min", 32'(min_out), 32'h7F);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t3_gf_busy2", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h44);
    chk("t3_go_clr", 32'(error), 32'd0);
    // 4: go during ACTIVE aborts
    step(1'b0, 1'b0, 1'b1, 8'h50);
    step(1'b1, 1'b0, 1'b0, 8'h01);
    chk("t4_abort_err", 32'(error), 32'd1);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4_abort_done", 32'(done), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4_abort_done2", 32'(done), 32'd0);
    chk("t4_hold_max", 32'(max_out), 32'h80);
    chk("t4_hold_rng", 32'(range), 32'h01);
    // lone finish in IDLE
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    // leave ACTIVE cleanly first: this session is not needed
    push_exp(8'h00, 8'h00, 8'h00, 4'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    expect_result("t3_dummy");
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_fin_err", 32'(error), 32'd1);
    chk("t3_fin_busy", 32'(busy), 32'd0);

    // 4b: gating of in_valid=0 samples
    step(1'b1, 1'b0, 1'b0, 8'h40);
    chk("t4_go_clr", 32'(error), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'hFF);
    push_exp(8'h40, 8'h60, 8'h20, 4'd2);
    step(1'b0, 1'b1, 1'b1, 8'h60);
    expect_result("t4g");

    // 5: counter saturation (go + 20 samples -> 21 attempted, sat at 15)
    step(1'b1, 1'b0, 1'b0, 8'h10);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(i + 1));
      if (i == 13) chk("t5_no_ovf_yet", 32'(overflow), 32'd0);
    end
    chk("t5_ovf_active", 32'(overflow), 32'd1);
    push_exp(8'h01, 8'h14, 8'h13, 4'd15);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    expect_result("t5");
    chk("t5_ovf", 32'(overflow), 32'd1);

    // 6: reset mid-session; go also clears overflow
    step(1'b1, 1'b0, 1'b0, 8'h09);
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h77);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_min", 32'(min_out), 32'd0);
    chk("t6_rst_max", 32'(max_out), 32'd0);
    chk("t6_rst_range", 32'(range), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    #3 reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t6_post_busy", 32'(busy), 32'd0);
    chk("t6_post_done", 32'(done), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h33);
    push_exp(8'h11, 8'h33, 8'h22, 4'd2);
    step(1'b0, 1'b1, 1'b1, 8'h11);
    expect_result("t6");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
